// File: rtl/vga_console_pkg.sv
// Shared definitions for the VGA text-console writer.
//   state_e      : top-level FSM states
//   cursor_op_e  : operations requested from the cursor block
//   ASC_*        : ASCII codes given special meaning by the console
//   TAB_STOP     : tab column spacing
//   is_printable : true for bytes that are drawn as glyphs
package vga_console_pkg;

  typedef enum logic [1:0] {
    INIT_CLR,
    IDLE,
    WRITE,
    CLR_ROW
  } state_e;

  typedef enum logic [2:0] {
    CUR_NONE,
    CUR_INC,
    CUR_NEWLINE,
    CUR_BACK,
    CUR_TAB
  } cursor_op_e;

  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_BS    = 8'h08;
  localparam logic [7:0] ASC_TAB   = 8'h09;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_TILDE = 8'h7E;

  localparam int unsigned TAB_STOP = 8;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= ASC_SPACE) && (c <= ASC_TILDE);
  endfunction

endpackage

// File: rtl/vga_console_writer_cursor.sv
// Cursor position for the text console.
//   clk_i, rst_ni : clock, asynchronous active-low reset (cursor -> (0,0))
//   op_i          : operation applied at the next rising edge
//   x_o, y_o      : current cursor column / row
//   x_next_o,
//   y_next_o      : position the cursor takes at the next edge for op_i
//   wrap_o        : op_i results in a newline (caller must clear the new row)
module console_cursor
  import vga_console_pkg::*;
#(
  parameter int unsigned COLS = 70,
  parameter int unsigned ROWS = 30
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  cursor_op_e op_i,
  output logic [6:0] x_o,
  output logic [5:0] y_o,
  output logic [6:0] x_next_o,
  output logic [5:0] y_next_o,
  output logic       wrap_o
);

  localparam logic [6:0] XMAX  = 7'(COLS - 1);
  localparam logic [5:0] YMAX  = 6'(ROWS - 1);
  localparam logic [7:0] COLS8 = 8'(COLS);

  logic [6:0] x_q, x_d;
  logic [5:0] y_q, y_d;
  logic       wrap;
  // Next tab stop strictly right of the cursor; 8 bits because it can reach 128.
  logic [7:0] tab_x;

  assign tab_x = 8'((32'(x_q) / TAB_STOP + 1) * TAB_STOP);

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    wrap = 1'b0;
    unique case (op_i)
      CUR_INC: begin
        if (x_q == XMAX) wrap = 1'b1;
        else             x_d  = x_q + 7'd1;
      end
      CUR_NEWLINE: wrap = 1'b1;
      CUR_BACK: begin
        if (x_q != 7'd0) x_d = x_q - 7'd1;
      end
      CUR_TAB: begin
        if (tab_x >= COLS8) wrap = 1'b1;
        else                x_d  = tab_x[6:0];
      end
      default: ;
    endcase
    // Newline wraps to the top row; there is no scrolling.
    if (wrap) begin
      x_d = 7'd0;
      y_d = (y_q == YMAX) ? 6'd0 : y_q + 6'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= 7'd0;
      y_q <= 6'd0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign x_next_o = x_d;
  assign y_next_o = y_d;
  assign wrap_o   = wrap;

endmodule

// File: rtl/vga_console_writer.sv
// Text-console front end driving the character video RAM write port.
//   clk, rstn          : clock, asynchronous active-low reset
//   in_valid, in_ascii : input byte stream, accepted when in_valid && in_ready
//   in_ready           : high only while idle
//   wren               : video RAM write strobe
//   w_ascii_addr_x/y   : write address; holds the cursor cell while idle
//   w_ascii            : write data
// Clears the whole screen after reset, then prints characters and handles
// newline / carriage return, backspace and tab. Every freshly entered row is
// cleared with BLANK before the next byte is accepted.
module vga_console_writer
  import vga_console_pkg::*;
#(
  parameter int unsigned COLS  = 70,
  parameter int unsigned ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       in_valid,
  input  logic [7:0] in_ascii,
  output logic       in_ready,
  output logic       wren,
  output logic [7:0] w_ascii_addr_x,
  output logic [7:0] w_ascii_addr_y,
  output logic [7:0] w_ascii
);

  localparam logic [6:0] XMAX = 7'(COLS - 1);
  localparam logic [5:0] YMAX = 6'(ROWS - 1);

  state_e     state_q, state_d;
  logic       wren_q, wren_d;
  logic       in_ready_q, in_ready_d;
  logic [6:0] ax_q, ax_d;
  logic [5:0] ay_q, ay_d;
  logic [7:0] data_q, data_d;
  // WRITE was entered for a printable byte, so the cursor advances afterwards.
  logic       adv_q, adv_d;
  // Clear scan position: next cell during INIT_CLR, current column in CLR_ROW.
  logic [6:0] clr_x_q, clr_x_d;
  logic [5:0] clr_y_q, clr_y_d;
  logic       done_q, done_d;

  cursor_op_e op;
  logic [6:0] cur_x, nx;
  logic [5:0] cur_y, ny;
  logic       wrap;
  logic       accept;

  console_cursor #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_cursor (
    .clk_i   (clk),
    .rst_ni  (rstn),
    .op_i    (op),
    .x_o     (cur_x),
    .y_o     (cur_y),
    .x_next_o(nx),
    .y_next_o(ny),
    .wrap_o  (wrap)
  );

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d    = state_q;
    wren_d     = 1'b0;
    in_ready_d = 1'b0;
    ax_d       = nx;
    ay_d       = ny;
    data_d     = data_q;
    adv_d      = adv_q;
    clr_x_d    = clr_x_q;
    clr_y_d    = clr_y_q;
    done_d     = done_q;
    op         = CUR_NONE;

    unique case (state_q)
      INIT_CLR: begin
        if (done_q) begin
          state_d    = IDLE;
          in_ready_d = 1'b1;
        end else begin
          wren_d = 1'b1;
          ax_d   = clr_x_q;
          ay_d   = clr_y_q;
          data_d = BLANK;
          if (clr_x_q == XMAX) begin
            clr_x_d = 7'd0;
            if (clr_y_q == YMAX) done_d  = 1'b1;
            else                 clr_y_d = clr_y_q + 6'd1;
          end else begin
            clr_x_d = clr_x_q + 7'd1;
          end
        end
      end

      IDLE: begin
        // After any accept in_ready drops for at least one cycle; for bytes
        // that produce no write this is the single idle cycle they cost.
        if (accept) begin
          if (is_printable(in_ascii)) begin
            state_d = WRITE;
            wren_d  = 1'b1;
            ax_d    = cur_x;
            ay_d    = cur_y;
            data_d  = in_ascii;
            adv_d   = 1'b1;
          end else if (in_ascii == ASC_LF || in_ascii == ASC_CR) begin
            op = CUR_NEWLINE;
          end else if (in_ascii == ASC_BS) begin
            if (cur_x != 7'd0) begin
              op      = CUR_BACK;
              state_d = WRITE;
              wren_d  = 1'b1;
              data_d  = BLANK;
              adv_d   = 1'b0;
            end
          end else if (in_ascii == ASC_TAB) begin
            op = CUR_TAB;
          end
        end else begin
          in_ready_d = 1'b1;
        end
      end

      WRITE: begin
        if (adv_q) op = CUR_INC;
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end

      CLR_ROW: begin
        if (clr_x_q == XMAX) begin
          state_d    = IDLE;
          in_ready_d = 1'b1;
        end else begin
          clr_x_d = clr_x_q + 7'd1;
          wren_d  = 1'b1;
          ax_d    = clr_x_q + 7'd1;
          ay_d    = cur_y;
          data_d  = BLANK;
        end
      end

      default: state_d = INIT_CLR;
    endcase

    // Any newline starts clearing the new row in the very next cycle.
    if (wrap) begin
      state_d    = CLR_ROW;
      wren_d     = 1'b1;
      in_ready_d = 1'b0;
      ax_d       = 7'd0;
      ay_d       = ny;
      data_d     = BLANK;
      clr_x_d    = 7'd0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= INIT_CLR;
      wren_q     <= 1'b0;
      in_ready_q <= 1'b0;
      ax_q       <= 7'd0;
      ay_q       <= 6'd0;
      data_q     <= BLANK;
      adv_q      <= 1'b0;
      clr_x_q    <= 7'd0;
      clr_y_q    <= 6'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wren_q     <= wren_d;
      in_ready_q <= in_ready_d;
      ax_q       <= ax_d;
      ay_q       <= ay_d;
      data_q     <= data_d;
      adv_q      <= adv_d;
      clr_x_q    <= clr_x_d;
      clr_y_q    <= clr_y_d;
      done_q     <= done_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign wren           = wren_q;
  assign w_ascii_addr_x = {1'b0, ax_q};
  assign w_ascii_addr_y = {2'b00, ay_q};
  assign w_ascii        = data_q;

endmodule
